// File: rtl/img_uart_dump.sv
// img_uart_dump: drains the processed-image destination RAM to a host over an
// 8N1 UART. Each 24-bit pixel is sent as three bytes (bits 23:16, 15:8, 7:0),
// LSB first, with no idle gap between bytes.
// Optional build macro UART_DUMP_GRAY_EN: send only bits 7:0 of each pixel,
// one byte per pixel, because the filtered image has equal channels.
module img_uart_dump #(
  parameter int RAM_ADDR_BITS = 10,
  parameter int RAM_WIDTH     = 24,
  parameter int NUM_PIXELS    = 1024,
  parameter int CLKS_PER_BIT  = 434
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  input  logic [RAM_WIDTH-1:0]     mem_do,
  output logic                     tx,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]         BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [RAM_ADDR_BITS-1:0] PIX_LAST = RAM_ADDR_BITS'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    LOAD,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    NEXT
  } state_t;

  state_t                   state_reg, state_next;
  logic [CNT_W-1:0]         clk_cnt_reg;
  logic [2:0]               bit_idx_reg;
  logic [7:0]               shift_reg;
  logic [RAM_ADDR_BITS-1:0] pix_idx_reg;
  logic [RAM_ADDR_BITS-1:0] mem_addr_reg;

  logic bit_end;
  logic last_pix;
  logic more_bytes;

  assign bit_end  = (clk_cnt_reg == BIT_LAST);
  assign last_pix = (pix_idx_reg == PIX_LAST);
  assign mem_addr = mem_addr_reg;

`ifdef UART_DUMP_GRAY_EN
  // Grayscale: the single byte per pixel is always the last one.
  assign more_bytes = 1'b0;
`else
  logic [1:0]  byte_idx_reg;
  // Bits 23:16 go out straight from mem_do in LOAD; only the low two bytes are kept.
  logic [15:0] pixel_lo_reg;

  assign more_bytes = (byte_idx_reg < 2'd2);

  // Byte index within the pixel and the two bytes still to be sent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx_reg <= 2'd0;
      pixel_lo_reg <= 16'd0;
    end else if (state_reg == LOAD) begin
      byte_idx_reg <= 2'd0;
      pixel_lo_reg <= mem_do[15:0];
    end else if (state_reg == STOP_BIT && bit_end && more_bytes) begin
      byte_idx_reg <= byte_idx_reg + 2'd1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and the serial/handshake outputs decoded from state.
  always_comb begin
    state_next = state_reg;
    tx         = 1'b1;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = FETCH;
      end
      FETCH: state_next = WAIT;
      WAIT:  state_next = LOAD;
      LOAD:  state_next = START_BIT;
      START_BIT: begin
        tx = 1'b0;
        if (bit_end) state_next = DATA_BITS;
      end
      DATA_BITS: begin
        tx = shift_reg[0];
        if (bit_end && bit_idx_reg == 3'd7) state_next = STOP_BIT;
      end
      STOP_BIT: begin
        if (bit_end) state_next = more_bytes ? START_BIT : NEXT;
      end
      NEXT: begin
        if (last_pix) begin
          done       = 1'b1;
          busy       = 1'b0;
          state_next = IDLE;
        end else begin
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit-period counter: runs only while a frame is on the line, wraps each bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_cnt_reg <= '0;
    end else if (state_reg == START_BIT || state_reg == DATA_BITS || state_reg == STOP_BIT) begin
      clk_cnt_reg <= bit_end ? '0 : clk_cnt_reg + CNT_W'(1);
    end else begin
      clk_cnt_reg <= '0;
    end
  end

  // Data bit index; wraps back to 0 after bit 7 so each byte starts fresh.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_idx_reg <= 3'd0;
    end else if (state_reg == DATA_BITS) begin
      if (bit_end) bit_idx_reg <= bit_idx_reg + 3'd1;
    end else begin
      bit_idx_reg <= 3'd0;
    end
  end

  // Byte shift register: loaded per byte, shifted right after each data bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= 8'd0;
    end else if (state_reg == LOAD) begin
`ifdef UART_DUMP_GRAY_EN
      shift_reg <= mem_do[7:0];
`else
      shift_reg <= mem_do[23:16];
`endif
    end else if (state_reg == DATA_BITS && bit_end) begin
      shift_reg <= {1'b0, shift_reg[7:1]};
    end else if (state_reg == STOP_BIT && bit_end && more_bytes) begin
`ifndef UART_DUMP_GRAY_EN
      shift_reg <= (byte_idx_reg == 2'd0) ? pixel_lo_reg[15:8] : pixel_lo_reg[7:0];
`endif
    end
  end

  // Pixel index: cleared when a run is accepted, stops at the last pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_idx_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      pix_idx_reg <= '0;
    end else if (state_reg == NEXT && !last_pix) begin
      pix_idx_reg <= pix_idx_reg + RAM_ADDR_BITS'(1);
    end
  end

  // RAM address: captured in FETCH and held until the next FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr_reg <= '0;
    end else if (state_reg == FETCH) begin
      mem_addr_reg <= pix_idx_reg;
    end
  end

endmodule

// File: tb/tb_img_uart_dump.sv
// tb_img_uart_dump: drives img_uart_dump against a small synchronous RAM and
// decodes the UART line with an independent receiver; expected bytes, run
// length and bit waveform are derived from the pixel contents alone.
module tb_img_uart_dump;

  localparam int AW    = 4;
  localparam int CPB   = 4;
  localparam int NP    = 2;
`ifdef UART_DUMP_GRAY_EN
  localparam int BPP   = 1;
`else
  localparam int BPP   = 3;
`endif
  localparam int FRAME    = 10 * CPB;
  localparam int EXP_DONE = NP * (4 + BPP * FRAME) - 1;
  localparam int ABORT_AT = (BPP == 3) ? (NP * 0 + 3 + 3 * FRAME + 1 + 3 + CPB + 2 * CPB + 2)
                                       : (3 + FRAME + 1 + 3 + CPB + 2 * CPB + 2);

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_do;
  logic          tx;
  logic          busy;
  logic          done;

  logic [23:0] ram [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic       tx_hist [0:4095];
  int done_cnt, done_cyc, busy_gap, frame_err;
  logic busy0, busy_at_done;

  img_uart_dump #(
    .RAM_ADDR_BITS(AW),
    .RAM_WIDTH(24),
    .NUM_PIXELS(NP),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mem_addr(mem_addr),
    .mem_do(mem_do),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM, one cycle latency.
  always @(posedge clk) mem_do <= ram[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the bytes a run must produce, straight from pixel contents.
  task automatic build_expected(input int runs);
    exp_q.delete();
    for (int r = 0; r < runs; r++) begin
      for (int p = 0; p < NP; p++) begin
        logic [23:0] w;
        w = ram[p];
        if (BPP == 3) begin
          exp_q.push_back(w[23:16]);
          exp_q.push_back(w[15:8]);
          exp_q.push_back(w[7:0]);
        end else begin
          exp_q.push_back(w[7:0]);
        end
      end
    end
  endtask

  // Cycle-by-cycle monitor with a mid-bit UART receiver; called at the
  // negedge just after start was accepted (cycle 0 = first busy cycle).
  task automatic collect(input int max_cyc, input int restart_at, input int abort_at);
    int fs;
    int off;
    logic [7:0] b;
    bit in_f;
    rx_q.delete();
    done_cnt = 0; done_cyc = -1; busy_gap = 0; frame_err = 0;
    busy_at_done = 1'bx; in_f = 0; fs = 0; b = 8'd0;
    busy0 = busy;
    for (int c = 0; c < max_cyc; c++) begin
      if (c > 0) @(negedge clk);
      tx_hist[c] = tx;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          busy_at_done = busy;
        end
      end
      if (done_cyc < 0 && !done && !busy) busy_gap++;
      if (!in_f) begin
        if (tx == 1'b0) begin
          in_f = 1; fs = c; b = 8'd0;
        end
      end else begin
        off = c - fs;
        if (off == CPB / 2 && tx !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++)
          if (off == CPB * (1 + i) + CPB / 2) b[i] = tx;
        if (off == 9 * CPB + CPB / 2) begin
          if (tx !== 1'b1) frame_err++;
          rx_q.push_back(b);
          in_f = 0;
        end
      end
      start = (c == restart_at);
      if (c == abort_at) begin
        reset = 1'b0;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_addr", mem_addr, 0);
        start = 1'b0;
        return;
      end
    end
    start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full run: start, monitor, compare against the reference.
  task automatic run_check(input string tag, input int restart_at, input int runs);
    int n;
    build_expected(runs);
    pulse_start();
    collect(runs * (EXP_DONE + 2) + 60, restart_at, -1);
    chk($sformatf("%s_busy0", tag), busy0, 1);
    chk($sformatf("%s_nbytes", tag), rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    chk($sformatf("%s_frame_err", tag), frame_err, 0);
    chk($sformatf("%s_done_cnt", tag), done_cnt, runs);
    chk($sformatf("%s_done_cyc", tag), done_cyc, EXP_DONE);
    chk($sformatf("%s_busy_gap", tag), busy_gap, 0);
    chk($sformatf("%s_busy_at_done", tag), busy_at_done, 0);
    chk($sformatf("%s_idle_busy", tag), busy, 0);
    chk($sformatf("%s_idle_tx", tag), tx, 1);
  endtask

  initial begin
    int zeros;
    int dn;
    logic [23:0] w0;
    logic [7:0]  fb;
    logic [3:0]  got4;
    logic        eb;

    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 24'h0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", mem_addr, 0);
    reset = 1'b1;
    zeros = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) zeros++;
    end
    chk("idle_200", zeros, 0);

    // Basic dump.
    ram[0] = 24'h123456;
    ram[1] = 24'hA5F00F;
    run_check("basic", -1, 1);

    // Bit timing and start latency on the first byte.
    ram[0] = 24'h550000;
    run_check("timing", -1, 1);
    w0 = ram[0];
    fb = (BPP == 3) ? w0[23:16] : w0[7:0];
    chk("lat_tx_c2", tx_hist[2], 1);
    chk("lat_tx_c3", tx_hist[3], 0);
    for (int k = 0; k < 10; k++) begin
      eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : fb[k-1];
      got4 = {tx_hist[3+CPB*k], tx_hist[4+CPB*k], tx_hist[5+CPB*k], tx_hist[6+CPB*k]};
      chk($sformatf("bit%0d", k), got4, {4{eb}});
    end

    // Start while busy (during the second byte) is ignored.
    ram[0] = 24'h123456;
    run_check("busy_start", 3 + FRAME + 20, 1);

    // Start in the same cycle as done is ignored.
    run_check("start_at_done", EXP_DONE, 1);

    // Start the cycle after done is accepted: two back-to-back runs.
    build_expected(2);
    pulse_start();
    collect(2 * (EXP_DONE + 2) + 60, EXP_DONE + 1, -1);
    chk("b2b_nbytes", rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      chk($sformatf("b2b_byte%0d", i), rx_q[i], exp_q[i]);
    chk("b2b_done_cnt", done_cnt, 2);

    // Reset in the middle of a data byte late in the run.
    pulse_start();
    collect(EXP_DONE + 10, -1, ABORT_AT);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) dn++;
    end
    chk("abort_hold", dn, 0);
    reset = 1'b1;
    @(negedge clk);
    run_check("after_abort", -1, 1);

    // Randomised pixel contents.
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < NP; p++) ram[p] = 24'($urandom);
      run_check($sformatf("rand%0d", r), -1, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/img_uart_dump.md
Name: img_uart_dump

Overview:
Reads the processed-image destination RAM word by word and streams each 24-bit pixel out as 8N1 UART bytes. It is the read-out end of the pixel-processing path: the processing sequencer fills the destination RAM, and this block drains it to a host.
It drives the RAM address port and consumes the synchronous read data, which has 1-cycle latency.

Parameters:
RAM_ADDR_BITS, 10, width of the pixel RAM address.
RAM_WIDTH, 24, pixel word width. Must be 24; three bytes per pixel.
NUM_PIXELS, 1024, number of words dumped per run, from address 0 to NUM_PIXELS-1. Range 1..2^RAM_ADDR_BITS.
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200). Minimum 2.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
mem_addr  output  RAM_ADDR_BITS  read address to the destination RAM.
mem_do  input  RAM_WIDTH  RAM read data, valid 1 cycle after mem_addr.
tx  output  1  UART serial out; idles high.
busy  output  1  high from the cycle after start is accepted until the end of the last stop bit.
done  output  1  one-cycle pulse after the last stop bit of the last pixel.

Behaviour:
- Reset (reset=0, asynchronous): all outputs are forced immediately, even mid-byte or mid-run, and the run is abandoned.
  - tx=1, busy=0, done=0, mem_addr=0.
  - state=IDLE; counters and shift register cleared.
- FSM states: IDLE, FETCH, WAIT, LOAD, START_BIT, DATA_BITS, STOP_BIT, NEXT.
- IDLE: tx=1. When start=1, go to FETCH with pixel index 0. start is ignored in every other state.
- FETCH: mem_addr = pixel index (held stable until the next FETCH). Next state is WAIT.
- WAIT: one cycle to absorb RAM latency.
- LOAD: latch mem_do into the pixel register; byte index = 0; go to START_BIT.
- Byte order per pixel: byte 0 = bits 23:16, byte 1 = bits 15:8, byte 2 = bits 7:0.
- Bit order within a byte: LSB first.
- START_BIT: tx=0 for CLKS_PER_BIT cycles.
- DATA_BITS: 8 bits, each held for CLKS_PER_BIT cycles.
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles. Then:
  - if byte index < 2: increment byte index, go to START_BIT;
  - otherwise go to NEXT.
- No idle gap between bytes: a stop bit is followed directly by the next start bit.
- NEXT:
  - if pixel index == NUM_PIXELS-1: done=1 for this cycle, busy drops, go to IDLE;
  - otherwise increment pixel index and go to FETCH.
- Wrap-around: pixel index never exceeds NUM_PIXELS-1. When NUM_PIXELS = 2^RAM_ADDR_BITS, the index does not wrap to 0 before done.
- Frame time: 10*CLKS_PER_BIT cycles per byte. Pixel overhead is 4 cycles (FETCH, WAIT, LOAD, NEXT), all with tx=1.
- Latency: start accepted -> tx falls 3 cycles later.
- start asserted in the same cycle done pulses: ignored (state is still NEXT). A start in the following cycle is accepted.
- mem_do is sampled only in LOAD; changes on mem_do at any other time have no effect.

Optional Feature:
UART_DUMP_GRAY_EN
- Defined: one byte per pixel (bits 7:0), since the filtered image is grayscale with equal channels. STOP_BIT always goes to NEXT, so a run is NUM_PIXELS bytes.
- Undefined: three bytes per pixel as described in Behaviour.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and NUM_PIXELS=2.
- Reset check: hold reset=0 -> tx=1, busy=0, done=0, mem_addr=0. Release reset, no start -> tx stays 1 for 200 cycles.
- Basic dump: RAM[0]=24'h123456, RAM[1]=24'hA5F00F, pulse start -> decoded bytes 12,34,56,A5,F0,0F.
  - Each frame has start=0 and stop=1.
  - done is a single pulse after byte 6; busy covers the whole run.
- Bit timing: RAM[0]=24'h550000 -> tx falls 3 cycles after start. Each bit is 4 cycles; first byte bits are 1,0,1,0,1,0,1,0, LSB first.
- Start while busy: pulse start again during byte 2 -> no restart, same 6 bytes, exactly one done.
- Reset mid-run: assert reset during the DATA_BITS of byte 4 -> tx=1 immediately, busy=0, no done. A new start dumps from address 0 again.
- With UART_DUMP_GRAY_EN: the same RAM contents as the basic dump -> bytes 56,0F only, then done.
